// File: rtl/rgb_sram_packer_pkg.sv
// Shared state encoding, pixel struct and frame-size constants for the RGB SRAM packer.
// Frame constants are given at the default 320x240 geometry; frame_pairs() derives them for other sizes.
package rgb_sram_packer_pkg;

   typedef enum logic [2:0] {
      S_RP_IDLE,
      S_RP_WAIT_P0,
      S_RP_WAIT_P1,
      S_RP_WR_1,
      S_RP_WR_2,
      S_RP_DONE
   } RGB_packer_state_type;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam int SRAM_AW        = 18;
   localparam int DEF_IMG_WIDTH  = 320;
   localparam int DEF_IMG_HEIGHT = 240;
   localparam int FRAME_PAIRS    = DEF_IMG_WIDTH * DEF_IMG_HEIGHT / 2;
   localparam int FRAME_WORDS    = 3 * FRAME_PAIRS;

   function automatic int frame_pairs(input int width, input int height);
      return width * height / 2;
   endfunction

endpackage

// File: rtl/rgb_sram_packer_test_pattern_gen.sv
// Eight vertical colour bars across the row; the column advances once per consumed pixel.
// Combinational pixel from a registered column counter; the consumer paces it through advance.
module rgb_test_pattern_gen
   import rgb_sram_packer_pkg::*;
#(
   parameter int IMG_WIDTH = 320
) (
   input  logic Clock,
   input  logic Reset,
   input  logic advance,
   output rgb_t pixel
);

   localparam int CW    = $clog2(IMG_WIDTH);
   localparam int BAR_W = IMG_WIDTH / 8;

   logic [CW-1:0] col;
   logic [2:0]    bar;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         col <= '0;
      end else if (advance) begin
         col <= (col == CW'(IMG_WIDTH - 1)) ? '0 : col + CW'(1);
      end
   end

   assign bar     = 3'(col / CW'(BAR_W));
   assign pixel.r = {8{bar[2]}};
   assign pixel.g = {8{bar[1]}};
   assign pixel.b = {8{bar[0]}};

endmodule

// File: rtl/rgb_sram_packer.sv
// Packs raster RGB pixel pairs into three 16-bit SRAM words at consecutive addresses; RGB_PACKER_TEST_PATTERN_EN swaps the stream for colour bars.
// First word of a pair 1 cycle after pixel 1 is taken; pixel_ready is low during the two follow-on writes (2 px / 5 cycles peak).
module rgb_sram_packer
   import rgb_sram_packer_pkg::*;
#(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Start,
   input  logic [SRAM_AW-1:0] SRAM_base_address,
   input  logic               pixel_valid,
   output logic               pixel_ready,
   input  logic [7:0]         pixel_R,
   input  logic [7:0]         pixel_G,
   input  logic [7:0]         pixel_B,
   output logic [SRAM_AW-1:0] SRAM_address,
   output logic [15:0]        SRAM_write_data,
   output logic               SRAM_we_n,
   output logic               Busy,
   output logic               Done
);

   localparam int PAIRS = frame_pairs(IMG_WIDTH, IMG_HEIGHT);
   localparam int CW    = $clog2(PAIRS + 1);

   RGB_packer_state_type state;
   logic [SRAM_AW-1:0]   ptr;
   logic [CW-1:0]        pair_cnt;
   rgb_t                 p0;
   rgb_t                 p1;
   rgb_t                 pix;
   logic                 xfer;

`ifdef RGB_PACKER_TEST_PATTERN_EN
   localparam logic STREAM_EN = 1'b0;
   logic unused_stream;

   assign unused_stream = ^{pixel_valid, pixel_R, pixel_G, pixel_B};
   assign xfer          = (state == S_RP_WAIT_P0) || (state == S_RP_WAIT_P1);

   rgb_test_pattern_gen #(
      .IMG_WIDTH (IMG_WIDTH)
   ) u_pattern (
      .Clock   (Clock),
      .Reset   (Reset),
      .advance (xfer),
      .pixel   (pix)
   );
`else
   localparam logic STREAM_EN = 1'b1;

   assign pix  = '{r: pixel_R, g: pixel_G, b: pixel_B};
   assign xfer = pixel_valid && pixel_ready;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state           <= S_RP_IDLE;
         ptr             <= '0;
         pair_cnt        <= '0;
         p0              <= '0;
         p1              <= '0;
         pixel_ready     <= 1'b0;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         SRAM_we_n       <= 1'b1;
         Busy            <= 1'b0;
         Done            <= 1'b0;
      end else begin
         SRAM_we_n <= 1'b1;
         Done      <= 1'b0;
         case (state)
            S_RP_IDLE: begin
               pixel_ready <= 1'b0;
               if (Start) begin
                  ptr      <= SRAM_base_address;
                  pair_cnt <= '0;
                  Busy     <= 1'b1;
                  state    <= S_RP_WAIT_P0;
               end
            end
            // ready rises one cycle into WAIT_P0 and stays up until pixel 1 is taken
            S_RP_WAIT_P0: begin
               pixel_ready <= STREAM_EN;
               if (xfer) begin
                  p0    <= pix;
                  state <= S_RP_WAIT_P1;
               end
            end
            S_RP_WAIT_P1: begin
               if (xfer) begin
                  p1              <= pix;
                  pixel_ready     <= 1'b0;
                  SRAM_address    <= ptr;
                  SRAM_write_data <= {p0.r, p0.g};
                  SRAM_we_n       <= 1'b0;
                  state           <= S_RP_WR_1;
               end else begin
                  pixel_ready <= STREAM_EN;
               end
            end
            S_RP_WR_1: begin
               SRAM_address    <= ptr + SRAM_AW'(1);
               SRAM_write_data <= {p0.b, p1.r};
               SRAM_we_n       <= 1'b0;
               state           <= S_RP_WR_2;
            end
            S_RP_WR_2: begin
               SRAM_address    <= ptr + SRAM_AW'(2);
               SRAM_write_data <= {p1.g, p1.b};
               SRAM_we_n       <= 1'b0;
               ptr             <= ptr + SRAM_AW'(3);
               pair_cnt        <= pair_cnt + CW'(1);
               state           <= (pair_cnt == CW'(PAIRS - 1)) ? S_RP_DONE : S_RP_WAIT_P0;
            end
            S_RP_DONE: begin
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= S_RP_IDLE;
            end
            default: state <= S_RP_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_sram_packer.sv
// Directed bench for rgb_sram_packer on a reduced 16x16 frame (128 pairs, 384 words).
module tb_rgb_sram_packer;

   localparam int W     = 16;
   localparam int H     = 16;
   localparam int PAIRS = W * H / 2;
   localparam int WORDS = 3 * PAIRS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [17:0] base = '0;
   logic        pv = 1'b0;
   logic [7:0]  pr = '0, pg = '0, pb = '0;
   logic        pixel_ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_data;
   logic        we_n;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [17:0] wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   logic [15:0] sram[int];
   int          done_cnt = 0;
   logic        done_busy = 1'b1;
   logic [23:0] px [0:1023];

   rgb_sram_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .Clock             (clk),
      .Reset             (rst),
      .Start             (start),
      .SRAM_base_address (base),
      .pixel_valid       (pv),
      .pixel_ready       (pixel_ready),
      .pixel_R           (pr),
      .pixel_G           (pg),
      .pixel_B           (pb),
      .SRAM_address      (sram_addr),
      .SRAM_write_data   (sram_data),
      .SRAM_we_n         (we_n),
      .Busy              (busy),
      .Done              (done)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (!we_n) begin
            wa.push_back(sram_addr);
            wd.push_back(sram_data);
            wc.push_back(cyc);
            sram[int'(sram_addr)] = sram_data;
         end
         if (done) begin
            done_cnt  = done_cnt + 1;
            done_busy = busy;
         end
      end
   end

   function automatic logic [15:0] exp_word(input int p, input int j);
      logic [23:0] a, b;
      a = px[2*p];
      b = px[2*p+1];
      case (j)
         0:       return a[23:8];
         1:       return {a[7:0], b[23:16]};
         default: return b[15:0];
      endcase
   endfunction

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      pv    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wa.delete();
      wd.delete();
      wc.delete();
      sram.delete();
      done_cnt  = 0;
      done_busy = 1'b1;
   endtask

   task automatic pulse_start(input logic [17:0] b);
      @(negedge clk);
      base  = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", pixel_ready); end
      checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
      checks++; if (sram_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", sram_data); end
      checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", we_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      do_reset();
      repeat (2) @(negedge clk);
      checks++; if (pixel_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset ready=%b busy=%b exp 0/0", pixel_ready, busy); end
   endtask

`ifdef RGB_PACKER_TEST_PATTERN_EN
   task automatic test_pattern();
      logic [15:0] ed [0:9];
      int          ei [0:9];
      do_reset();
      ed = '{16'h0000, 16'h0000, 16'hFF00, 16'h00FF, 16'h00FF, 16'h0000, 16'hFF00, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      ei = '{0, 3, 4, 5, 6, 7, 8, 21, 22, 23};
      pulse_start(18'h0);
      repeat (60) @(negedge clk);
      checks++; if (pixel_ready !== 1'b0) begin errors++; $display("FAIL pattern_ready got=%b exp=0", pixel_ready); end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (wd.size() <= ei[k]) begin
            errors++; $display("FAIL pattern_missing word %0d got=%0d writes", ei[k], wd.size());
         end else if (wd[ei[k]] !== ed[k] || wa[ei[k]] !== 18'(ei[k])) begin
            errors++; $display("FAIL pattern_word%0d got=%h@%h exp=%h@%h", ei[k], wd[ei[k]], wa[ei[k]], ed[k], 18'(ei[k]));
         end
      end
   endtask
`else
   task automatic stream(input int first, input int n, input bit rnd, input int budget);
      int  i = first;
      int  t = 0;
      bit  v;
      bit  ok;
      while (i < first + n && t < budget) begin
         @(negedge clk);
         v  = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
         {pr, pg, pb} = px[i];
         pv = v;
         ok = v && pixel_ready;
         @(posedge clk);
         if (ok) i++;
         t++;
      end
      @(negedge clk);
      pv = 1'b0;
      checks++;
      if (i != first + n) begin errors++; $display("FAIL stream_timeout accepted=%0d exp=%0d", i - first, n); end
   endtask

   task automatic check_model(input logic [17:0] b, input int nw, input string tag);
      logic [17:0] ea;
      logic [15:0] ed;
      for (int w = 0; w < nw; w++) begin
         ea = b + 18'(w);
         ed = exp_word(w / 3, w % 3);
         checks++;
         if (w >= wa.size()) begin
            errors++; $display("FAIL %s_missing word %0d got=%0d writes", tag, w, wa.size());
            break;
         end else if (wa[w] !== ea || wd[w] !== ed) begin
            errors++; $display("FAIL %s_word%0d got=%h@%h exp=%h@%h", tag, w, wd[w], wa[w], ed, ea);
         end
      end
   endtask

   task automatic test_first_pair();
      logic [15:0] ed [0:2];
      do_reset();
      ed = '{16'h1122, 16'h3344, 16'h5566};
      px[0] = 24'h112233;
      px[1] = 24'h445566;
      pulse_start(18'h0);
      stream(0, 2, 1'b0, 20);
      repeat (4) @(negedge clk);
      checks++;
      if (wa.size() != 3) begin
         errors++; $display("FAIL first_pair_count got=%0d exp=3", wa.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wa[k] !== 18'(k) || wd[k] !== ed[k]) begin
               errors++; $display("FAIL first_pair_word%0d got=%h@%h exp=%h@%h", k, wd[k], wa[k], ed[k], 18'(k));
            end
         end
         checks++;
         if (wc[1] != wc[0] + 1 || wc[2] != wc[1] + 1) begin
            errors++; $display("FAIL first_pair_consecutive got cycles %0d,%0d,%0d exp consecutive", wc[0], wc[1], wc[2]);
         end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_pair_busy got=%b exp=1", busy); end
   endtask

   task automatic test_full_frame();
      logic [17:0] b = 18'h00100;
      logic [15:0] w0, w1, w2;
      logic [23:0] got;
      int          p;
      do_reset();
      for (int i = 0; i < W * H; i++) px[i] = {8'(i), 8'(i * 37 + 11), 8'((i * 3) ^ 8'hA5)};
      pulse_start(b);
      stream(0, W * H, 1'b0, 2000);
      for (int t = 0; t < 50 && done_cnt == 0; t++) @(negedge clk);
      repeat (5) @(negedge clk);
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done got=%b exp=0", done_busy); end
      checks++; if (wa.size() != WORDS) begin errors++; $display("FAIL frame_word_count got=%0d exp=%0d", wa.size(), WORDS); end
      checks++;
      if (wa.size() == 0 || wa[wa.size()-1] !== 18'h0027F) begin
         errors++; $display("FAIL frame_last_addr got=%h exp=0027f", (wa.size() == 0) ? 18'h0 : wa[wa.size()-1]);
      end
      check_model(b, WORDS, "frame");
      for (int i = 0; i < W * H; i++) begin
         p  = i / 2;
         w0 = sram.exists(int'(b) + 3*p)     ? sram[int'(b) + 3*p]     : 16'hxxxx;
         w1 = sram.exists(int'(b) + 3*p + 1) ? sram[int'(b) + 3*p + 1] : 16'hxxxx;
         w2 = sram.exists(int'(b) + 3*p + 2) ? sram[int'(b) + 3*p + 2] : 16'hxxxx;
         got = (i % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
         checks++;
         if (got !== px[i]) begin errors++; $display("FAIL readback_px%0d got=%h exp=%h", i, got, px[i]); end
      end
      checks++; if (busy !== 1'b0 || pixel_ready !== 1'b0) begin errors++; $display("FAIL frame_idle busy=%b ready=%b exp 0/0", busy, pixel_ready); end
   endtask

   task automatic test_random_valid();
      do_reset();
      for (int i = 0; i < 40; i++) px[i] = {8'(i * 7 + 1), 8'(i ^ 8'h3C), 8'(200 - i)};
      pulse_start(18'h02000);
      stream(0, 40, 1'b1, 2000);
      repeat (5) @(negedge clk);
      checks++; if (wa.size() != 60) begin errors++; $display("FAIL random_word_count got=%0d exp=60", wa.size()); end
      check_model(18'h02000, 60, "random");
   endtask

   task automatic test_wrap();
      logic [17:0] ea [0:2];
      logic [15:0] ed [0:2];
      do_reset();
      ea = '{18'h3FFFE, 18'h3FFFF, 18'h00000};
      ed = '{16'hA1B2, 16'hC3D4, 16'hE5F6};
      px[0] = 24'hA1B2C3;
      px[1] = 24'hD4E5F6;
      pulse_start(18'h3FFFE);
      stream(0, 2, 1'b0, 20);
      repeat (4) @(negedge clk);
      checks++;
      if (wa.size() != 3) begin
         errors++; $display("FAIL wrap_count got=%0d exp=3", wa.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wa[k] !== ea[k] || wd[k] !== ed[k]) begin
               errors++; $display("FAIL wrap_word%0d got=%h@%h exp=%h@%h", k, wd[k], wa[k], ed[k], ea[k]);
            end
         end
      end
   endtask

   task automatic test_start_then_reset();
      int n_before;
      do_reset();
      for (int i = 0; i < 200; i++) px[i] = {8'(i), 8'(255 - i), 8'(i * 11)};
      pulse_start(18'h00500);
      stream(0, 20, 1'b0, 200);
      pulse_start(18'h09000);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
      stream(20, 180, 1'b0, 1000);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL abort_we_n got=%b exp=1", we_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
      n_before = wa.size();
      checks++; if (n_before < 297) begin errors++; $display("FAIL abort_words got=%0d exp>=297", n_before); end
      check_model(18'h00500, n_before, "restart");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (wa.size() != n_before) begin errors++; $display("FAIL abort_extra_writes got=%0d exp=%0d", wa.size(), n_before); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got=%b exp=0", busy); end
   endtask
`endif

   initial begin
      test_reset();
`ifdef RGB_PACKER_TEST_PATTERN_EN
      test_pattern();
`else
      test_first_pair();
      test_full_frame();
      test_random_valid();
      test_wrap();
      test_start_then_reset();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
